// File: rtl/seq_ratio_div.sv
// seq_ratio_div: multi-cycle restoring divider, one quotient bit per clock.
// mode 0 gives floor(num/den); mode 1 gives floor(num*2^Q_W/den) as a Q0.Q_W fraction.
// Define SEQ_DIV_ROUND_EN to add a guard-bit iteration that rounds the quotient up.
module seq_ratio_div #(
    parameter int unsigned N_W = 16,
    parameter int unsigned Q_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mode,
    input  logic [N_W-1:0] num,
    input  logic [N_W-1:0] den,
    output logic           busy,
    output logic           done,
    output logic [Q_W-1:0] quotient,
    output logic [N_W-1:0] remainder,
    output logic           div_zero,
    output logic           sat
);

    localparam int unsigned R_W = N_W + 1;
`ifdef SEQ_DIV_ROUND_EN
    localparam int unsigned EXTRA = 1;
`else
    localparam int unsigned EXTRA = 0;
`endif
    localparam int unsigned CNT_W = $clog2(N_W + EXTRA + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic           mode_q;
    logic [N_W-1:0] den_q;
    logic [N_W-1:0] nsh_q;      // dividend bits still to be shifted in (integer mode)
    logic [N_W-1:0] r_q;        // partial remainder; always < den between iterations
    logic [N_W-1:0] quo_q;
    logic [CNT_W-1:0] cnt_q;

    logic           busy_q;
    logic           done_q;
    logic [Q_W-1:0] quotient_q;
    logic [N_W-1:0] remainder_q;
    logic           div_zero_q;
    logic           sat_q;

    // Iteration datapath
    logic [R_W-1:0] r_shift;
    logic [R_W-1:0] den_ext;
    logic           r_ge;
    logic [N_W-1:0] r_d;
    logic [N_W-1:0] quo_d;
    logic [N_W-1:0] nsh_d;
    logic [CNT_W-1:0] last_cnt;

    // Final result shaping
    logic [N_W-1:0] fin_quo;
    logic [N_W-1:0] fin_rem;
    logic           guard;
    logic [Q_W-1:0] low_quo;
    logic           over;
    logic [Q_W-1:0] fin_q;
    logic           fin_sat;

    // Short-circuit decode on an accepted start
    logic           sc_zero;
    logic           sc_sat;

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign sat       = sat_q;

    // One restoring step: shift in the next dividend bit (or 0 in fraction mode), trial-subtract
    always_comb begin
        r_shift  = {r_q, (mode_q ? 1'b0 : nsh_q[N_W-1])};
        den_ext  = {1'b0, den_q};
        r_ge     = (r_shift >= den_ext);
        r_d      = r_ge ? N_W'(r_shift - den_ext) : N_W'(r_shift);
        quo_d    = (quo_q << 1) | N_W'(r_ge);
        nsh_d    = nsh_q << 1;
        last_cnt = mode_q ? CNT_W'(Q_W - 1 + EXTRA) : CNT_W'(N_W - 1 + EXTRA);
    end

    // Clamp to Q_W bits, apply optional guard-bit rounding
    always_comb begin
`ifdef SEQ_DIV_ROUND_EN
        // Guard iteration: quotient and remainder are the pre-rounding values already held
        fin_quo = quo_q;
        fin_rem = r_q;
        guard   = r_ge;
`else
        fin_quo = quo_d;
        fin_rem = r_d;
        guard   = 1'b0;
`endif
        low_quo = fin_quo[Q_W-1:0];
        over    = ((fin_quo >> Q_W) != '0);
        fin_q   = '0;
        fin_sat = 1'b0;
        if (over || (guard && (&low_quo))) begin
            fin_q   = '1;
            fin_sat = 1'b1;
        end else begin
            fin_q   = low_quo + Q_W'(guard);
            fin_sat = 1'b0;
        end
    end

    // Divide-by-zero and fraction >= 1 resolve without iterating
    always_comb begin
        sc_zero = (den == '0);
        sc_sat  = mode && (num >= den);
    end

    // Control FSM with registered results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            den_q       <= '0;
            nsh_q       <= '0;
            r_q         <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_CALC: begin
                    r_q   <= r_d;
                    quo_q <= quo_d;
                    nsh_q <= nsh_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == last_cnt) begin
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= fin_q;
                        remainder_q <= fin_rem;
                        div_zero_q  <= 1'b0;
                        sat_q       <= fin_sat;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new start
                    if (start) begin
                        mode_q <= mode;
                        den_q  <= den;
                        nsh_q  <= num;
                        quo_q  <= '0;
                        cnt_q  <= '0;
                        r_q    <= mode ? num : '0;
                        if (sc_zero) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= num;
                            div_zero_q  <= 1'b1;
                            sat_q       <= 1'b0;
                        end else if (sc_sat) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= num - den;
                            div_zero_q  <= 1'b0;
                            sat_q       <= 1'b1;
                        end else begin
                            state_q <= S_CALC;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_ratio_div.sv
// Self-checking bench for seq_ratio_div: vector table plus corner-case sequences,
// results checked through an expected-value queue popped on each done pulse.
module tb_seq_ratio_div;

    localparam int unsigned N_W = 16;
    localparam int unsigned Q_W = 8;
`ifdef SEQ_DIV_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           mode;
    logic [N_W-1:0] num;
    logic [N_W-1:0] den;
    logic           busy;
    logic           done;
    logic [Q_W-1:0] quotient;
    logic [N_W-1:0] remainder;
    logic           div_zero;
    logic           sat;

    typedef struct {
        logic [Q_W-1:0] q;
        logic [N_W-1:0] rem;
        logic           dz;
        logic           sat;
    } exp_t;

    typedef struct {
        logic           m;
        logic [N_W-1:0] n;
        logic [N_W-1:0] d;
        exp_t           e;
        int             lat;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    seq_ratio_div #(.N_W(N_W), .Q_W(Q_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .num       (num),
        .den       (den),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic vec_t mk(input logic m, input int n, input int d, input int q,
                                input int rem, input logic dz, input logic s, input int lat);
        vec_t v;
        v.m     = m;
        v.n     = N_W'(n);
        v.d     = N_W'(d);
        v.e.q   = Q_W'(q);
        v.e.rem = N_W'(rem);
        v.e.dz  = dz;
        v.e.sat = s;
        v.lat   = lat;
        return v;
    endfunction

    // Compare result fields whenever the DUT reports done
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: done high with no outstanding request at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                check("quotient", 64'(quotient), 64'(mon_e.q));
                check("remainder", 64'(remainder), 64'(mon_e.rem));
                check("div_zero", 64'(div_zero), 64'(mon_e.dz));
                check("sat", 64'(sat), 64'(mon_e.sat));
            end
        end
    end

    // Issue one start pulse and measure edges until done
    task automatic run_op(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        mode  = v.m;
        num   = v.n;
        den   = v.d;
        start = 1'b1;
        sb.push_back(v.e);
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 1'($urandom);
        num   = N_W'($urandom);
        den   = N_W'($urandom);
        lat   = 1;
        check({tag, "_busy"}, 64'(busy), 64'(v.lat > 1));
        while (done !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(v.lat));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[14];
        vec_t v4;
        exp_t e6;
        int   lat;
        int   seen;
        int   pulses;
        int   edges[8];
        int   per;
        int   np;

        vt[0]  = mk(1'b1, 22000, 22727, 247 + RND, 18431, 1'b0, 1'b0, 9 + RND);
        vt[1]  = mk(1'b0, 1000, 7, 142 + RND, 6, 1'b0, 1'b0, 17 + RND);
        vt[2]  = mk(1'b0, 5000, 3, 255, 2, 1'b0, 1'b1, 17 + RND);
        vt[3]  = mk(1'b1, 22727, 22727, 255, 0, 1'b0, 1'b1, 1);
        vt[4]  = mk(1'b1, 22727, 0, 255, 22727, 1'b1, 1'b0, 1);
        vt[5]  = mk(1'b1, 0, 22727, 0, 0, 1'b0, 1'b0, 9 + RND);
        vt[6]  = mk(1'b0, 1234, 0, 255, 1234, 1'b1, 1'b0, 1);
        vt[7]  = mk(1'b0, 255, 1, 255, 0, 1'b0, 1'b0, 17 + RND);
        vt[8]  = mk(1'b0, 256, 1, 255, 0, 1'b0, 1'b1, 17 + RND);
        vt[9]  = mk(1'b1, 1, 3, 85, 1, 1'b0, 1'b0, 9 + RND);
        vt[10] = mk(1'b1, 2, 3, 170 + RND, 2, 1'b0, 1'b0, 9 + RND);
        vt[11] = mk(1'b1, 65534, 65535, 255, 65279, 1'b0, 1'(RND), 9 + RND);
        vt[12] = mk(1'b0, 511, 2, 255, 1, 1'b0, 1'(RND), 17 + RND);
        vt[13] = mk(1'b1, 40000, 30000, 255, 10000, 1'b0, 1'b1, 1);

        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        num   = '0;
        den   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({busy, done, quotient, remainder, div_zero, sat}), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Table vectors, issued back-to-back on each done cycle
        for (int i = 0; i < 14; i++) begin
            run_op(vt[i], $sformatf("vec%0d", i));
        end

        // Start during CALC is ignored; first result and latency unchanged
        v4 = vt[1];
        @(negedge clk);
        mode  = v4.m;
        num   = v4.n;
        den   = v4.d;
        start = 1'b1;
        sb.push_back(v4.e);
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        mode  = 1'b0;
        num   = 16'd5000;
        den   = 16'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat++;
        while (done !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("midcalc_start_latency", 64'(lat), 64'(v4.lat));
        run_op(vt[0], "after_midcalc");

        // Asynchronous reset four cycles into CALC abandons the operation
        @(negedge clk);
        mode  = 1'b0;
        num   = 16'd1000;
        den   = 16'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("busy_before_reset", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 64'({busy, done, quotient, remainder, div_zero, sat}), 64'(0));
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        check("no_done_after_reset", 64'(seen), 64'(0));
        run_op(vt[1], "after_reset");

        // Held start: a new division is accepted on every done cycle
        per   = 9 + RND;
        np    = (RND != 0) ? 3 : 4;
        e6.q   = Q_W'(247 + RND);
        e6.rem = N_W'(18431);
        e6.dz  = 1'b0;
        e6.sat = 1'b0;
        @(negedge clk);
        mode  = 1'b1;
        num   = 16'd22000;
        den   = 16'd22727;
        start = 1'b1;
        repeat (np) sb.push_back(e6);
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (k == 29) start = 1'b0;
            if (done === 1'b1) begin
                if (pulses < 8) edges[pulses] = k;
                pulses++;
            end
        end
        check("held_pulse_count", 64'(pulses), 64'(np));
        for (int i = 0; i < np && i < pulses && i < 8; i++) begin
            check($sformatf("held_pulse%0d_edge", i), 64'(edges[i]), 64'(per - 1 + i * per));
        end

        @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_ratio_div.md
Name: seq_ratio_div

Overview:
Parameterised multi-cycle restoring divider for tone and clock-divider computations in the synth datapath. It generalises the fixed 16-bit-in, 8-bit-out divider with configurable widths and two modes: integer quotient, or scaled fraction num/den in Q0.Q_W. It adds a start/busy/done handshake, remainder output, divide-by-zero and saturation flags. One quotient bit is resolved per clock.

Parameters:
N_W, 16, width of the num, den and remainder operands.
Q_W, 8, quotient width. Must satisfy 1 <= Q_W <= N_W.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request a division; sampled on the rising edge.
mode  in  1  0 = integer quotient floor(num/den); 1 = fraction floor(num*2^Q_W/den).
num  in  N_W  dividend, unsigned; captured when start is accepted.
den  in  N_W  divisor, unsigned; captured when start is accepted.
busy  out  1  high while in CALC.
done  out  1  one-cycle pulse; results valid from this cycle.
quotient  out  Q_W  result; held until the next done.
remainder  out  N_W  final partial remainder; held until the next done.
div_zero  out  1  den was 0 for the last result.
sat  out  1  true quotient exceeded 2^Q_W-1 and was clamped.

Behaviour:
- Reset: state IDLE. busy, done, quotient, remainder, div_zero and sat all 0. Reset during CALC abandons the operation with no done.
- States: IDLE, CALC, DONE.
- Start acceptance:
  - Start is accepted in IDLE or DONE, so a new start can be issued on the done cycle for back-to-back operation.
  - Start is ignored in CALC.
  - On acceptance: capture num, den and mode; clear the iteration counter; partial remainder R (N_W+1 bits) = 0.
- Short-circuit path (accepted start goes directly to DONE, so done is high in the cycle after the accepting edge):
  - den == 0: quotient = all ones, remainder = num, div_zero = 1, sat = 0.
  - mode = 1 and num >= den: quotient = all ones, remainder = num - den, sat = 1, div_zero = 0.
- CALC, integer mode (N_W iterations, MSB first):
  - Each iteration: R = {R, next num bit}; if R >= den then R -= den and the quotient bit is 1.
  - Internal quotient is N_W bits wide.
  - If any bit above Q_W-1 is set: quotient = all ones, sat = 1. Otherwise quotient = low Q_W bits.
- CALC, fraction mode (Q_W iterations):
  - R is initialised with num.
  - Each iteration: R = R << 1; if R >= den then R -= den and the quotient bit is 1.
  - sat = 0 on this path.
- Outputs are registered on the edge of the final iteration; state moves to DONE and done = 1 for exactly one cycle.
- Latency, accepting edge to done high: N_W+1 cycles (integer), Q_W+1 cycles (fraction), 1 cycle (short-circuit).
- DONE: if start is absent, return to IDLE on the next edge.
- Flags and results are updated only on entry to DONE and hold otherwise.
- Operand inputs may change freely after acceptance.

Optional Feature:
SEQ_DIV_ROUND_EN
- Defined:
  - One extra iteration after the last quotient bit computes a guard bit; if the guard bit is 1, quotient is incremented.
  - An increment that would overflow clamps to all ones and sets sat.
  - Remainder reports the value before rounding.
  - CALC latency grows by one cycle; short-circuit paths are unchanged.
- Undefined: truncating (floor) results only, with latencies as above.

Test Plan:
1. Defaults, mode=1, num=22000, den=22727, 1-cycle start -> done exactly 9 edges after start; quotient=247, remainder=18431, sat=0. With SEQ_DIV_ROUND_EN: quotient=248, done at 10 edges.
2. mode=0, num=1000, den=7 -> done after 17 edges; quotient=142, remainder=6. Then num=5000, den=3 -> quotient=255, sat=1, remainder=2.
3. mode=1, num=den=22727 -> done 1 cycle later, quotient=255, sat=1. Then den=0 -> quotient=255, div_zero=1, remainder=num. Then num=0, den=22727 -> quotient=0, remainder=0, flags clear.
4. Start pulsed again mid-CALC with different operands -> ignored; first result reported unchanged. A start on the done cycle -> accepted, and the second done follows with correct latency.
5. Assert rst 4 cycles into CALC -> all outputs 0 immediately (asynchronous), no done. After release, a fresh division completes correctly.
6. Held start for 30 cycles, mode=1, num=22000, den=22727 -> done pulses every 9 cycles, each pulse with quotient=247.
